// File: rtl/sw_traceback_unit.sv
// rtl/sw_traceback_unit.sv - collects one solver tile, tracks the max cell, streams its arrow path back
module sw_traceback_unit #(
    parameter int DIM    = 16,
    parameter int VAL_W  = 8,
    parameter int TILE_W = 4,
    parameter int OFF_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TILE_W-1:0] sel_tile,
    input  logic              in_valid,
    input  logic [TILE_W-1:0] in_tile,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [1:0]        in_arrow,
    input  logic [VAL_W-1:0]  in_val,
    output logic              busy,
    output logic [VAL_W-1:0]  max_val,
    output logic [3:0]        max_row,
    output logic [3:0]        max_col,
    output logic              tb_valid,
    input  logic              tb_ready,
    output logic [3:0]        tb_row,
    output logic [3:0]        tb_col,
    output logic [1:0]        tb_arrow,
    output logic              tb_last,
    output logic              done
);
    localparam int CELLS = DIM * DIM;

    typedef enum logic [2:0] {IDLE, COLLECT, TR_READ, TR_EMIT, DONE_S} state_t;

    state_t            state, state_nx;
    logic [TILE_W-1:0] tile_q;
    logic [8:0]        cell_cnt;
    logic [3:0]        cur_row, cur_col;
    logic [1:0]        ram [CELLS];
    logic [1:0]        rd_arrow;
    logic              accept, upd, last_cell, emit, is_last, handshake;
    logic [VAL_W-1:0]  final_max;

    assign accept    = (state == COLLECT) && in_valid && (in_tile == tile_q);
    assign upd       = accept && (in_val > max_val);
    assign last_cell = accept && (cell_cnt == 9'(CELLS - 1));
    assign final_max = upd ? in_val : max_val;
    assign emit      = (state == TR_EMIT);
    assign handshake = emit && tb_ready;

    // Path ends on a stop arrow or when the next step would leave the tile edge.
    always_comb begin
        is_last = 1'b0;
        case (rd_arrow)
            2'b00: is_last = 1'b1;
            2'b01: is_last = (cur_row == 4'd0);
            2'b10: is_last = (cur_col == 4'd0);
            2'b11: is_last = (cur_row == 4'd0) || (cur_col == 4'd0);
            default: is_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = COLLECT;
            COLLECT: if (last_cell) state_nx = (final_max == '0) ? DONE_S : TR_READ;
            TR_READ: state_nx = TR_EMIT;
            TR_EMIT: if (handshake) state_nx = is_last ? DONE_S : TR_READ;
            DONE_S:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cur_row/cur_col follow the running max so traceback starts there without an extra load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tile_q   <= '0;
            cell_cnt <= '0;
            max_val  <= '0;
            max_row  <= '0;
            max_col  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
        end else begin
            if (state == IDLE && start) begin
                tile_q   <= sel_tile;
                cell_cnt <= '0;
                max_val  <= '0;
                max_row  <= '0;
                max_col  <= '0;
                cur_row  <= '0;
                cur_col  <= '0;
            end
            if (accept) cell_cnt <= cell_cnt + 9'd1;
            if (upd) begin
                max_val <= in_val;
                max_row <= in_offset[7:4];
                max_col <= in_offset[3:0];
                cur_row <= in_offset[7:4];
                cur_col <= in_offset[3:0];
            end
            if (handshake && !is_last) begin
                cur_row <= cur_row - {3'b000, rd_arrow[0]};
                cur_col <= cur_col - {3'b000, rd_arrow[1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) ram[in_offset] <= in_arrow;
        if (state == TR_READ) rd_arrow <= ram[{cur_row, cur_col}];
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE_S);
    assign tb_valid = emit;
    assign tb_row   = emit ? cur_row : 4'd0;
    assign tb_col   = emit ? cur_col : 4'd0;
    assign tb_arrow = emit ? rd_arrow : 2'b00;
    assign tb_last  = emit && is_last;
endmodule

// File: tb/tb_sw_traceback_unit.sv
// tb/tb_sw_traceback_unit.sv - directed bench for sw_traceback_unit
module tb_sw_traceback_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] sel_tile = '0;
    logic       in_valid = 1'b0;
    logic [3:0] in_tile = '0;
    logic [7:0] in_offset = '0;
    logic [1:0] in_arrow = '0;
    logic [7:0] in_val = '0;
    logic       busy, tb_valid, tb_last, done;
    logic       tb_ready = 1'b1;
    logic [7:0] max_val;
    logic [3:0] max_row, max_col, tb_row, tb_col;
    logic [1:0] tb_arrow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] arr_a [256];
    logic [7:0] val_a [256];
    logic [3:0] br, bc, sr, sc;
    logic [1:0] ba, sa;
    logic       bl, sl;
    int         dones;

    sw_traceback_unit dut (
        .clk(clk), .reset(reset), .start(start), .sel_tile(sel_tile),
        .in_valid(in_valid), .in_tile(in_tile), .in_offset(in_offset),
        .in_arrow(in_arrow), .in_val(in_val), .busy(busy), .max_val(max_val),
        .max_row(max_row), .max_col(max_col), .tb_valid(tb_valid),
        .tb_ready(tb_ready), .tb_row(tb_row), .tb_col(tb_col),
        .tb_arrow(tb_arrow), .tb_last(tb_last), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [1:0] a, input logic [7:0] v);
        for (int i = 0; i < 256; i++) begin
            arr_a[i] = a;
            val_a[i] = v;
        end
    endtask

    task automatic do_start(input logic [3:0] t);
        @(negedge clk);
        start = 1'b1;
        sel_tile = t;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [3:0] t, input logic [7:0] off, input logic [1:0] a, input logic [7:0] v);
        in_valid = 1'b1;
        in_tile = t;
        in_offset = off;
        in_arrow = a;
        in_val = v;
    endtask

    // Cells lo..hi in offset order; with noise, 20 foreign-tile beats are interleaved.
    task automatic stream(input logic [3:0] t, input bit noise, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (noise && i < 240 && (i % 12) == 5) begin
                @(negedge clk);
                drive(4'd4, 8'(i), 2'b11, 8'hff);
            end
            @(negedge clk);
            drive(t, 8'(i), arr_a[i], val_a[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_beat(input string tag);
        int cnt = 0;
        while (!tb_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_valid"}, tb_valid, 1);
        br = tb_row; bc = tb_col; ba = tb_arrow; bl = tb_last;
        @(negedge clk);
    endtask

    task automatic expect_beat(input string tag, input logic [3:0] r, input logic [3:0] c,
                               input logic [1:0] a, input logic l);
        get_beat(tag);
        check({tag, "_row"}, br, r);
        check({tag, "_col"}, bc, c);
        check({tag, "_arrow"}, ba, a);
        check({tag, "_last"}, bl, l);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_max", max_val, 0);
        check("rst_valid", tb_valid, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // diagonal path from (5,5) to (0,0)
        fill(2'b00, 8'd1);
        for (int k = 0; k <= 5; k++) arr_a[k * 16 + k] = 2'b11;
        val_a[8'h55] = 8'd10;
        do_start(4'd3);
        stream(4'd3, 1'b0, 0, 255);
        check("diag_lat_read", tb_valid, 0);
        check("diag_busy", busy, 1);
        check("diag_max", max_val, 10);
        check("diag_maxrow", max_row, 5);
        check("diag_maxcol", max_col, 5);
        @(negedge clk);
        check("diag_lat_emit", tb_valid, 1);
        for (int k = 5; k >= 0; k--) expect_beat($sformatf("diag%0d", k), 4'(k), 4'(k), 2'b11, k == 0);
        check("diag_done", done, 1);
        @(negedge clk);
        check("diag_done_pulse", done, 0);
        check("diag_idle", busy, 0);

        // arrow-00 stop
        fill(2'b11, 8'd1);
        val_a[8'h79] = 8'd200; arr_a[8'h79] = 2'b10;
        arr_a[8'h78] = 2'b01;
        arr_a[8'h68] = 2'b00;
        do_start(4'd5);
        stream(4'd5, 1'b0, 0, 255);
        expect_beat("stop0", 4'd7, 4'd9, 2'b10, 1'b0);
        expect_beat("stop1", 4'd7, 4'd8, 2'b01, 1'b0);
        expect_beat("stop2", 4'd6, 4'd8, 2'b00, 1'b1);
        check("stop_done", done, 1);

        // tie keeps earliest, foreign tile filtered
        fill(2'b00, 8'd5);
        val_a[8'h12] = 8'd50;
        val_a[8'h40] = 8'd50; arr_a[8'h40] = 2'b11;
        do_start(4'd3);
        stream(4'd3, 1'b1, 0, 254);
        @(negedge clk);
        @(negedge clk);
        check("tie_still_busy", busy, 1);
        check("tie_no_early_valid", tb_valid, 0);
        check("tie_no_early_done", done, 0);
        stream(4'd3, 1'b0, 255, 255);
        check("tie_max", max_val, 50);
        check("tie_row", max_row, 1);
        check("tie_col", max_col, 2);
        expect_beat("tie_b0", 4'd1, 4'd2, 2'b00, 1'b1);
        check("tie_done", done, 1);

        // zero-score tile
        fill(2'b11, 8'd0);
        do_start(4'd2);
        stream(4'd2, 1'b0, 0, 255);
        check("zero_done", done, 1);
        check("zero_valid", tb_valid, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_idle", busy, 0);
        check("zero_max", max_val, 0);

        // backpressure with ignored start
        fill(2'b11, 8'd1);
        val_a[8'h22] = 8'd99; arr_a[8'h22] = 2'b10;
        arr_a[8'h21] = 2'b00;
        tb_ready = 1'b0;
        do_start(4'd7);
        stream(4'd7, 1'b0, 0, 255);
        @(negedge clk);
        check("bp_valid", tb_valid, 1);
        sr = tb_row; sc = tb_col; sa = tb_arrow; sl = tb_last;
        check("bp_row0", sr, 2);
        check("bp_col0", sc, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin start = 1'b1; sel_tile = 4'd9; end
            else start = 1'b0;
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {tb_valid, tb_row, tb_col, tb_arrow, tb_last},
                  {1'b1, sr, sc, sa, sl});
        end
        start = 1'b0;
        tb_ready = 1'b1;
        expect_beat("bp_b0", 4'd2, 4'd2, 2'b10, 1'b0);
        expect_beat("bp_b1", 4'd2, 4'd1, 2'b00, 1'b1);
        check("bp_done", done, 1);
        check("bp_max_kept", max_val, 99);
        @(negedge clk);
        check("bp_idle", busy, 0);

        // reset in the middle of a traceback
        fill(2'b11, 8'd1);
        val_a[8'h79] = 8'd200; arr_a[8'h79] = 2'b10;
        arr_a[8'h78] = 2'b01;
        tb_ready = 1'b0;
        do_start(4'd6);
        stream(4'd6, 1'b0, 0, 255);
        @(negedge clk);
        check("mid_valid_before", tb_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_async_outs", {busy, tb_valid, tb_last, done, tb_row, tb_col, tb_arrow},
              32'd0);
        check("mid_async_max", {max_val, max_row, max_col}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tb_ready = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_busy", busy, 0);
        check("mid_max", max_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_traceback_unit.md
Name: sw_traceback_unit

Overview:
- Downstream consumer of the 16x16 alignment cell solver.
- Collects the cells of one tile: per-cell val, arrow, tileNumOut and offsetOut, qualified by valid.
- Stores each cell's arrow in a 256x2 traceback RAM and tracks the maximum score and its location.
- After the tile completes, walks the arrow path back from the maximum cell and streams it out over a valid/ready handshake.

Parameters:
- DIM, 16, tile edge; tile holds DIM*DIM cells.
- VAL_W, 8, score width.
- TILE_W, 4, tile number width.
- OFF_W, 8, cell offset width; offset[7:4] = row, offset[3:0] = col.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins collection of tile sel_tile.
- sel_tile  in  TILE_W  tile to collect; sampled on start.
- in_valid  in  1  cell result valid (solver valid).
- in_tile  in  TILE_W  cell tile number (solver tileNumOut).
- in_offset  in  OFF_W  cell position (solver offsetOut).
- in_arrow  in  2  00 stop, 01 from up, 10 from left, 11 from diagonal.
- in_val  in  VAL_W  cell score.
- busy  out  1  high in any state other than IDLE.
- max_val  out  VAL_W  highest score in the collected tile.
- max_row  out  4  row of max_val.
- max_col  out  4  col of max_val.
- tb_valid  out  1  traceback beat valid.
- tb_ready  in  1  downstream accepts beat.
- tb_row  out  4  row of beat cell.
- tb_col  out  4  col of beat cell.
- tb_arrow  out  2  stored arrow of beat cell.
- tb_last  out  1  final beat of path.
- done  out  1  one-cycle pulse when traceback completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including max_val/max_row/max_col.
  - cell_cnt=0.
  - RAM contents undefined; never read before written in a tile pass.
- States:
  - IDLE -> COLLECT on start. Captures sel_tile, clears cell_cnt, max_val, max_row and max_col.
  - start is ignored in every non-IDLE state.
- COLLECT:
  - A beat is accepted when in_valid=1 and in_tile==captured tile.
  - On accept: RAM[in_offset] <= in_arrow; cell_cnt increments (9 bits).
  - If in_val > max_val (strict), update max_val/row/col. Ties keep the earliest beat.
  - Beats with a mismatched tile are dropped silently.
  - Duplicate offsets overwrite the RAM entry and still count; upstream guarantees unique offsets.
  - When cell_cnt reaches 255 and a beat is accepted, the next state is TR_READ, or DONE if the final max_val==0. The max update from that final beat is included in this decision.
  - No backpressure; in_valid outside COLLECT is ignored.
- TR_READ:
  - Present address {cur_row,cur_col}, initialised to max location; synchronous RAM read, 1-cycle latency.
  - Always goes to TR_EMIT next cycle.
- TR_EMIT:
  - tb_valid=1. tb_row/tb_col = cur location; tb_arrow = read data.
  - tb_last=1 when any of:
    - arrow==00;
    - arrow==01 and row==0;
    - arrow==10 and col==0;
    - arrow==11 and (row==0 or col==0).
  - All tb_* outputs are held stable while tb_valid && !tb_ready.
  - On handshake, not last: move 01 -> row-1, 10 -> col-1, 11 -> both -1; go to TR_READ.
  - On handshake with last: go to DONE.
  - Minimum 2 cycles per beat.
- DONE:
  - done=1 for one cycle, then IDLE.
  - max_val/row/col held until the next start.
- Latency:
  - Last collected beat accepted in cycle N: TR_READ in N+1, first tb_valid in N+2.
  - Zero-max case: done in N+1 with no beats.
- Mid-operation reset: returns to IDLE immediately; an in-flight traceback is abandoned with no done pulse.
- Width rule: row/col decrement is never allowed to wrap; the tb_last edge rule guarantees this.

Test Plan:
- Reset mid-traceback:
  - Stimulus: drop reset while tb_valid=1.
  - Required: all outputs 0 asynchronously; after release, busy=0 and max_val=0.
- Diagonal path:
  - Stimulus: start tile 3; stream 256 cells; cell (5,5) val=10, cells (k,k) for k<5 arrow=11, (0,0) arrow=11; all others val<10.
  - Required: max=10 at (5,5); beats (5,5)…(0,0); tb_last only on (0,0); done 1 cycle after that handshake.
- Arrow-00 stop:
  - Stimulus: (7,9) val=200 arrow=10; (7,8) arrow=01; (6,8) arrow=00.
  - Required: 3 beats; tb_last on (6,8) with tb_arrow=00.
- Tie and tile filter:
  - Stimulus: val=50 first at offset 0x12, later at 0x40; interleave 20 beats with in_tile=4 while collecting tile 3.
  - Required: max_row=1, max_col=2; mismatched beats not counted; completion occurs only after the 256th tile-3 beat.
- Zero-score tile:
  - Stimulus: all in_val=0.
  - Required: no tb_valid; done pulses the cycle after the 256th accept.
- Backpressure:
  - Stimulus: hold tb_ready=0 for 5 cycles on a beat.
  - Required: tb_row/col/arrow/last stable throughout; start pulses during traceback ignored.
